instr_fetch_unit: RTL and testbench

- Upstream neighbour of the single-cycle CPU core.
- Owns the fetch PC and issues word-addressed requests to instruction memory over a valid/ready channel with variable response latency.
- Buffers returned instructions in a small in-order prefetch queue and hands them to the decode/execute stage with a valid/ready handshake.
- Accepts a redirect (branch taken) from the core, then flushes queued and in-flight instructions.

---
 rtl/ifu_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/instr_fetch_unit.sv | 137 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
// Widths, reset PC default, fetch FSM encoding, queue entry layout.
package ifu_pkg;

  localparam int          INSTR_W      = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
  localparam logic [31:0] NOP          = 32'h0;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] data;
    logic [31:0]        pc;
  } q_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order FIFO with occupancy count and synchronous flush.
// Ports: clk, rst_n, push_i/wdata_i, pop_i, flush_i, rdata_o (head, 0 when empty), count_o.
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             empty, full;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !empty && !flush_i;
  assign count_o = cnt_q;
  assign rdata_o = empty ? '0 : mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  // Upstream credit accounting must keep us from ever overflowing.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(do_push && full && !do_pop)
  );

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC, imem request/response handling and prefetch queue feeding the core.
// Ports: clock/reset(async low), imem_req_*, imem_rsp_*, redirect_*, instr_*; perf_* when IFU_PERF_EN.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter logic [31:0] RESET_PC        = RESET_PC_DEF,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [31:0]        instr_pc
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_discarded
`endif
);

  localparam int          CW     = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW-1:0] q_cnt, t_cnt;
  logic [31:0]   t_head;
  q_entry_t      q_head, q_wdata;
  logic          req_fire, drop, q_push, q_pop;
  logic          unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  // Outstanding count is the tag FIFO occupancy; queue+in-flight bounds credit.
  assign imem_req_valid = reset && (state_q == RUN) && !redirect_valid
                       && (({1'b0, q_cnt} + {1'b0, t_cnt}) < DEPTH_C)
                       && (t_cnt < MAX_C);
  assign imem_req_addr  = {2'b00, fetch_pc_q[31:2]};

  assign req_fire = imem_req_valid && imem_req_ready;
  // A response landing in a redirect cycle belongs to the old stream.
  assign drop     = imem_rsp_valid && (redirect_valid || (discard_q != '0));
  assign q_push   = imem_rsp_valid && !drop;
  assign q_pop    = instr_valid && instr_ready;
  assign q_wdata  = '{data: imem_rsp_data, pc: t_head};

  assign instr_valid = (q_cnt != '0);
  assign instr_data  = instr_valid ? q_head.data : NOP;
  assign instr_pc    = q_head.pc;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    state_d    = state_q;
    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      discard_d  = t_cnt - CW'(imem_rsp_valid);
      state_d    = (discard_d != '0) ? DRAIN : RUN;
    end else begin
      if (drop) discard_d = discard_q - CW'(1);
      if ((state_q == DRAIN) && (discard_q == '0)) state_d = RUN;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      fetch_pc_q <= RESET_PC;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(q_entry_t))
  ) u_queue (
    .clk     (clock),
    .rst_n   (reset),
    .push_i  (q_push),
    .pop_i   (q_pop),
    .flush_i (redirect_valid),
    .wdata_i (q_wdata),
    .rdata_o (q_head),
    .count_o (q_cnt)
  );

  // Tags are never flushed: dropped responses still retire their tag.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_tags (
    .clk     (clock),
    .rst_n   (reset),
    .push_i  (req_fire),
    .pop_i   (imem_rsp_valid),
    .flush_i (1'b0),
    .wdata_i (fetch_pc_q),
    .rdata_o (t_head),
    .count_o (t_cnt)
  );

`ifdef IFU_PERF_EN
  logic [31:0] perf_fetched_q, perf_discarded_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_fetched_q   <= '0;
      perf_discarded_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_q + 32'(q_pop && !redirect_valid);
      perf_discarded_q <= perf_discarded_q + 32'(drop)
                        + (redirect_valid ? 32'(q_cnt) : 32'd0);
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_discarded = perf_discarded_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a latency-configurable memory model.
// Expected instructions are queued at request time and matched at core pops.
module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        instr_valid;
  logic        instr_ready    = 1'b0;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetched, perf_discarded;
`endif

  always #5 clock = ~clock;

  instr_fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc)
`ifdef IFU_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_discarded (perf_discarded)
`endif
  );

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct { bit has; ent_t e; ent_t g; } pair_t;

  pend_t       pend[$];
  ent_t        sb[$];
  pair_t       pairs[$];
  logic [31:0] fires[$];
  int lat = 1, edge_n = 0, rsp_n = 0;
  int errors = 0, checks = 0;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_model();
    pend.delete(); sb.delete(); pairs.delete(); fires.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    rsp_n = 0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    redirect_valid = 1'b0;
    clear_model();
    repeat (2) @(negedge clock);
    reset  = 1'b1;
    edge_n = 0;
  endtask

  // One clock: sample at negedge+1, advance memory model at posedge.
  task automatic step();
    logic fire, pop, rsp;
    logic [31:0] fa;
    pair_t p;
    #1;
    fire = imem_req_valid && imem_req_ready;
    fa   = imem_req_addr;
    rsp  = imem_rsp_valid;
    pop  = instr_valid && instr_ready && !redirect_valid;
    if (redirect_valid) sb.delete();
    if (pop) begin
      p.g   = {instr_pc, instr_data};
      p.has = sb.size() > 0;
      if (p.has) p.e = sb.pop_front();
      else p.e = '0;
      pairs.push_back(p);
    end
    if (fire) begin
      sb.push_back({fa << 2, fa << 4});
      fires.push_back(fa);
    end
    @(posedge clock);
    edge_n++;
    if (rsp) begin
      void'(pend.pop_front());
      rsp_n++;
    end
    if (fire) pend.push_back('{addr: fa, due: edge_n + lat - 1});
    @(negedge clock);
    if (pend.size() > 0 && pend[0].due <= edge_n) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend[0].addr << 4;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks += 5;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid got=%b exp=0", instr_valid); end
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
    if (instr_data !== 32'h0) begin errors++; $display("FAIL rst_instr_data got=%h exp=0", instr_data); end
    if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc got=%h exp=0", instr_pc); end
    if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_req_addr got=%h exp=0", imem_req_addr); end
`ifdef IFU_PERF_EN
    checks += 2;
    if (perf_fetched !== 32'h0) begin errors++; $display("FAIL rst_perf_fetched got=%0d exp=0", perf_fetched); end
    if (perf_discarded !== 32'h0) begin errors++; $display("FAIL rst_perf_discarded got=%0d exp=0", perf_discarded); end
`endif
    @(posedge clock);
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid_clk got=%b exp=0", imem_req_valid); end
  endtask

  task automatic test_stream();
    pair_t p;
    lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (instr_valid !== (k >= 2)) begin
        errors++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", k, instr_valid, k >= 2);
      end
      if (k >= 2) begin
        checks++;
        if (instr_pc !== 32'((k - 2) * 4)) begin
          errors++; $display("FAIL stream_pc cyc=%0d got=%h exp=%h", k, instr_pc, (k - 2) * 4);
        end
      end
      step();
    end
    while (pairs.size() > 0) begin
      p = pairs.pop_front();
      checks++;
      if (!p.has || p.g !== p.e) begin
        errors++; $display("FAIL stream_order got pc=%h data=%h exp pc=%h data=%h", p.g.pc, p.g.data, p.e.pc, p.e.data);
      end
    end
  endtask

  task automatic test_stall();
    pair_t p;
    int n;
    lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b0;
    apply_reset();
    repeat (10) step();
    #1;
    checks += 2;
    if (fires.size() != 4) begin errors++; $display("FAIL stall_req_count got=%0d exp=4", fires.size()); end
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_req_valid got=%b exp=0", imem_req_valid); end
    instr_ready = 1'b1;
    n = 0;
    while (pairs.size() < 5 && n < 20) begin step(); n++; end
    checks++;
    if (pairs.size() < 5) begin
      errors++; $display("FAIL stall_timeout got=%0d pops exp=5", pairs.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (pairs[i].g.pc !== 32'(i * 4)) begin
          errors++; $display("FAIL stall_pc idx=%0d got=%h exp=%h", i, pairs[i].g.pc, i * 4);
        end
      end
    end
    checks++;
    if (fires.size() < 5 || fires[4] !== 32'h4) begin
      errors++; $display("FAIL stall_resume_addr got=%h exp=4", fires.size() > 4 ? fires[4] : 32'hx);
    end
    while (pairs.size() > 0) begin
      p = pairs.pop_front();
      checks++;
      if (!p.has || p.g !== p.e) begin
        errors++; $display("FAIL stall_order got pc=%h data=%h exp pc=%h data=%h", p.g.pc, p.g.data, p.e.pc, p.e.data);
      end
    end
  endtask

  task automatic test_redirect_drain();
    pair_t p;
    int n, base_f, base_r;
    lat = 3; imem_req_ready = 1'b1; instr_ready = 1'b1;
    apply_reset();
    n = 0;
    while (pend.size() != 3 && n < 20) begin step(); n++; end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    base_f = fires.size();
    base_r = rsp_n;
    step();
    redirect_valid = 1'b0;
    n = 0;
    while (fires.size() == base_f && n < 20) begin step(); n++; end
    checks++;
    if (fires.size() == base_f) begin
      errors++; $display("FAIL drain_timeout no request after redirect");
    end else begin
      checks += 2;
      if (fires[base_f] !== 32'h40) begin errors++; $display("FAIL drain_addr got=%h exp=40", fires[base_f]); end
      if (rsp_n - base_r != 3) begin errors++; $display("FAIL drain_dropped got=%0d exp=3", rsp_n - base_r); end
    end
    n = 0;
    while (pairs.size() < 3 && n < 20) begin step(); n++; end
    checks++;
    if (pairs.size() == 0 || pairs[0].g.pc !== 32'h100) begin
      errors++; $display("FAIL drain_first_pc got=%h exp=100", pairs.size() > 0 ? pairs[0].g.pc : 32'hx);
    end
    while (pairs.size() > 0) begin
      p = pairs.pop_front();
      checks++;
      if (!p.has || p.g !== p.e) begin
        errors++; $display("FAIL drain_order got pc=%h data=%h exp pc=%h data=%h", p.g.pc, p.g.data, p.e.pc, p.e.data);
      end
    end
  endtask

  task automatic test_redirect_wrap();
    pair_t p;
    int n, bf, bp;
    lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    apply_reset();
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    bf = fires.size(); bp = pairs.size();
    step();
    redirect_valid = 1'b0;
    n = 0;
    while (pairs.size() == bp && n < 20) begin step(); n++; end
    checks += 2;
    if (fires.size() <= bf || fires[bf] !== 32'h80) begin
      errors++; $display("FAIL wrap_align_addr got=%h exp=80", fires.size() > bf ? fires[bf] : 32'hx);
    end
    if (pairs.size() <= bp || pairs[bp].g.pc !== 32'h200) begin
      errors++; $display("FAIL wrap_align_pc got=%h exp=200", pairs.size() > bp ? pairs[bp].g.pc : 32'hx);
    end
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    bf = fires.size();
    step();
    redirect_valid = 1'b0;
    n = 0;
    while (fires.size() < bf + 2 && n < 20) begin step(); n++; end
    checks += 2;
    if (fires.size() < bf + 1 || fires[bf] !== 32'h3FFF_FFFF) begin
      errors++; $display("FAIL wrap_top_addr got=%h exp=3fffffff", fires.size() > bf ? fires[bf] : 32'hx);
    end
    if (fires.size() < bf + 2 || fires[bf+1] !== 32'h0) begin
      errors++; $display("FAIL wrap_zero_addr got=%h exp=0", fires.size() > bf + 1 ? fires[bf+1] : 32'hx);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h500;
    bf = fires.size();
    step();
    redirect_pc = 32'h600;
    step();
    redirect_valid = 1'b0;
    n = 0;
    while (fires.size() == bf && n < 20) begin step(); n++; end
    checks++;
    if (fires.size() == bf || fires[bf] !== 32'h180) begin
      errors++; $display("FAIL b2b_redirect_addr got=%h exp=180", fires.size() > bf ? fires[bf] : 32'hx);
    end
    repeat (4) step();
    while (pairs.size() > 0) begin
      p = pairs.pop_front();
      checks++;
      if (!p.has || p.g !== p.e) begin
        errors++; $display("FAIL wrap_order got pc=%h data=%h exp pc=%h data=%h", p.g.pc, p.g.data, p.e.pc, p.e.data);
      end
    end
  endtask

  task automatic test_req_stall();
    pair_t p;
    lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    apply_reset();
    repeat (3) step();
    imem_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks += 2;
      if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", k, imem_req_valid); end
      if (imem_req_addr !== 32'h3) begin errors++; $display("FAIL hold_addr cyc=%0d got=%h exp=3", k, imem_req_addr); end
      step();
    end
    imem_req_ready = 1'b1;
    repeat (6) step();
    while (pairs.size() > 0) begin
      p = pairs.pop_front();
      checks++;
      if (!p.has || p.g !== p.e) begin
        errors++; $display("FAIL hold_order got pc=%h data=%h exp pc=%h data=%h", p.g.pc, p.g.data, p.e.pc, p.e.data);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b0;
    apply_reset();
    n = 0;
    while (rsp_n < 2 && n < 10) begin step(); n++; end
    #1;
    checks++;
    if (instr_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%b exp=1", instr_valid); end
    #1 reset = 1'b0;
    clear_model();
    #1;
    checks += 2;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL mid_instr_valid got=%b exp=0", instr_valid); end
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_req_valid got=%b exp=0", imem_req_valid); end
`ifdef IFU_PERF_EN
    checks += 2;
    if (perf_fetched !== 32'h0) begin errors++; $display("FAIL mid_perf_fetched got=%0d exp=0", perf_fetched); end
    if (perf_discarded !== 32'h0) begin errors++; $display("FAIL mid_perf_discarded got=%0d exp=0", perf_discarded); end
`endif
    @(negedge clock);
    reset  = 1'b1;
    edge_n = 0;
    instr_ready = 1'b1;
    n = 0;
    while (pairs.size() == 0 && n < 10) begin step(); n++; end
    checks += 2;
    if (fires.size() == 0 || fires[0] !== 32'h0) begin
      errors++; $display("FAIL mid_restart_addr got=%h exp=0", fires.size() > 0 ? fires[0] : 32'hx);
    end
    if (pairs.size() == 0 || !pairs[0].has || pairs[0].g !== pairs[0].e || pairs[0].g.pc !== 32'h0) begin
      errors++; $display("FAIL mid_restart_pc got=%h exp=0", pairs.size() > 0 ? pairs[0].g.pc : 32'hx);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drain();
    test_redirect_wrap();
    test_req_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
